// File: rtl/cpu_pkg.sv
// Shared constants and types for the Simple RISC Machine control unit.
// Opcode/op encodings, FSM states, memory command and write-back select codes.
package cpu_pkg;

    localparam logic [2:0] OPC_B   = 3'b001;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MEM     = 2'b00;
    localparam logic [1:0] OP_BR      = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    typedef enum logic [4:0] {
        S_RESET,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_C,
        S_ADDR,
        S_LOAD_ADDR,
        S_MEM_RD1,
        S_MEM_RD2,
        S_GET_BD,
        S_PASS_B,
        S_MEM_WR,
        S_BRANCH,
        S_HALT
    } state_t;

    // flags: [0]=Z, [1]=N, [2]=V
    function automatic logic branch_taken(
        input logic [2:0] cond,
        input logic [2:0] flags
    );
        logic z;
        logic lt;
        logic res;
        z   = flags[0];
        lt  = flags[1] ^ flags[2];
        res = 1'b0;
        case (cond)
            3'b000:  res = 1'b1;
            3'b001:  res = z;
            3'b010:  res = ~z;
            3'b011:  res = lt;
            3'b100:  res = z | lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_control_instr_dec.sv
// Instruction field extraction for the control unit.
// Purely combinational: IR in, register selects and immediates out.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  shift,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/sequence unit: Moore FSM driving the datapath controls,
// plus the instruction register, program counter and data-address register.
module cpu_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] read_data,
    input  logic [15:0] datapath_out,
    input  logic [2:0]  flags,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [8:0]  pc,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        halted
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic [8:0]  addr_reg;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  ir_shift;
    logic        taken;
    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_alu;
    logic        is_ldr;
    logic        is_str;
    logic        is_b;
    logic        unused_dp;

    instr_dec u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .shift  (ir_shift),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

    // Only the low 9 bits of C form a memory address.
    assign unused_dp = ^datapath_out[15:9];

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_ldr     = (opcode == OPC_LDR) && (op == OP_MEM);
    assign is_str     = (opcode == OPC_STR) && (op == OP_MEM);
    assign is_b       = (opcode == OPC_B) && (op == OP_BR);
    assign taken      = branch_taken(rn, flags);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= '0;
            ir       <= '0;
            addr_reg <= '0;
        end else begin
            unique case (state)
                S_RESET:     pc <= '0;
                S_IF2:       ir <= read_data;
                S_UPDATE_PC: pc <= pc + 9'd1;
                S_LOAD_ADDR: addr_reg <= datapath_out[8:0];
                S_BRANCH: begin
                    if (taken) begin
                        pc <= pc + sximm8[8:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_RESET:     next_state = S_IF1;
            S_IF1:       next_state = S_IF2;
            S_IF2:       next_state = S_UPDATE_PC;
            S_UPDATE_PC: next_state = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_mov_imm: next_state = S_WRITE_IMM;
                    is_mov_reg: next_state = S_GET_B;
                    is_alu, is_ldr, is_str: next_state = S_GET_A;
                    is_b:       next_state = S_BRANCH;
                    default:    next_state = S_HALT;
                endcase
            end
            S_WRITE_IMM: next_state = S_IF1;
            S_GET_A:     next_state = is_alu ? S_GET_B : S_ADDR;
            S_GET_B:     next_state = S_ALU;
            S_ALU: begin
                next_state = (is_alu && op == OP_CMP) ? S_IF1 : S_WRITE_C;
            end
            S_WRITE_C:   next_state = S_IF1;
            S_ADDR:      next_state = S_LOAD_ADDR;
            S_LOAD_ADDR: next_state = is_ldr ? S_MEM_RD1 : S_GET_BD;
            S_MEM_RD1:   next_state = S_MEM_RD2;
            S_MEM_RD2:   next_state = S_IF1;
            S_GET_BD:    next_state = S_PASS_B;
            S_PASS_B:    next_state = S_MEM_WR;
            S_MEM_WR:    next_state = S_IF1;
            S_BRANCH:    next_state = S_IF1;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_RESET;
        endcase
    end

    always_comb begin
        mem_cmd  = MEM_NONE;
        mem_addr = '0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = '0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = '0;
        ALUop    = '0;
        halted   = 1'b0;
        unique case (state)
            S_IF1, S_IF2: begin
                mem_cmd  = MEM_READ;
                mem_addr = pc;
            end
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                shift   = ir_shift;
            end
            S_ALU: begin
                shift = ir_shift;
                loadc = 1'b1;
                if (is_alu) begin
                    ALUop = op;
                    loads = (op == OP_CMP);
                end else begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                end
            end
            S_WRITE_C: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                ALUop = ALU_ADD;
                loadc = 1'b1;
            end
            S_MEM_RD1: begin
                mem_cmd  = MEM_READ;
                mem_addr = addr_reg;
            end
            S_MEM_RD2: begin
                mem_cmd  = MEM_READ;
                mem_addr = addr_reg;
                writenum = rd;
                vsel     = VSEL_MDATA;
                write    = 1'b1;
            end
            S_GET_BD: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            S_PASS_B: begin
                asel  = 1'b1;
                ALUop = ALU_ADD;
                loadc = 1'b1;
            end
            S_MEM_WR: begin
                mem_cmd  = MEM_WRITE;
                mem_addr = addr_reg;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: a memory model feeds directed programs,
// expected control snapshots are queued and a monitor thread compares them.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] read_data = 16'h0000;
    logic [15:0] datapath_out;
    logic [2:0]  flags;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [8:0]  pc;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        halted;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [2:0]  rdn;
        logic [2:0]  wrn;
        logic        wr;
        logic [3:0]  vs;
        logic        la;
        logic        lb;
        logic        lc;
        logic        ls;
        logic        as;
        logic        bs;
        logic [1:0]  sh;
        logic [1:0]  alu;
        logic [15:0] imm;
    } ev_t;

    typedef struct {
        ev_t   e;
        string tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem [0:511];
    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    ev_t         mon_g;
    exp_t        mon_x;

    cpu_control dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read_data    (read_data),
        .datapath_out (datapath_out),
        .flags        (flags),
        .mem_cmd      (mem_cmd),
        .mem_addr     (mem_addr),
        .pc           (pc),
        .readnum      (readnum),
        .writenum     (writenum),
        .write        (write),
        .vsel         (vsel),
        .loada        (loada),
        .loadb        (loadb),
        .loadc        (loadc),
        .loads        (loads),
        .asel         (asel),
        .bsel         (bsel),
        .shift        (shift),
        .ALUop        (ALUop),
        .sximm5       (sximm5),
        .sximm8       (sximm8),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        read_data <= (mem_cmd == 2'b01) ? mem[mem_addr] : 16'h0000;
    end

    function automatic logic [63:0] ctl();
        return 64'({mem_cmd, mem_addr, pc, readnum, writenum, write, vsel,
                    loada, loadb, loadc, loads, asel, bsel, shift, ALUop,
                    halted});
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push(input ev_t e, input string tag);
        exp_t x;
        x.e   = e;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic x_fetch(input logic [8:0] a);
        ev_t e;
        e      = '0;
        e.cmd  = 2'b01;
        e.addr = a;
        push(e, $sformatf("IF1_%0d", a));
        push(e, $sformatf("IF2_%0d", a));
    endtask

    task automatic x_wimm(input logic [2:0] rn, input logic [15:0] imm);
        ev_t e;
        e     = '0;
        e.wrn = rn;
        e.vs  = 4'b0100;
        e.wr  = 1'b1;
        e.imm = imm;
        push(e, "WRITE_IMM");
    endtask

    task automatic x_geta(input logic [2:0] rn);
        ev_t e;
        e     = '0;
        e.rdn = rn;
        e.la  = 1'b1;
        push(e, "GET_A");
    endtask

    task automatic x_getb(input logic [2:0] rm, input logic [1:0] sh);
        ev_t e;
        e     = '0;
        e.rdn = rm;
        e.lb  = 1'b1;
        e.sh  = sh;
        push(e, "GET_B");
    endtask

    task automatic x_alu(input logic [1:0] sh, input logic [1:0] alu,
                         input logic ls, input logic as);
        ev_t e;
        e     = '0;
        e.sh  = sh;
        e.lc  = 1'b1;
        e.alu = alu;
        e.ls  = ls;
        e.as  = as;
        push(e, "ALU");
    endtask

    task automatic x_wc(input logic [2:0] rd);
        ev_t e;
        e     = '0;
        e.wrn = rd;
        e.vs  = 4'b0001;
        e.wr  = 1'b1;
        push(e, "WRITE_C");
    endtask

    task automatic x_addr();
        ev_t e;
        e    = '0;
        e.bs = 1'b1;
        e.lc = 1'b1;
        push(e, "ADDR");
    endtask

    task automatic x_rd(input logic [8:0] a, input logic [2:0] rd);
        ev_t e;
        e      = '0;
        e.cmd  = 2'b01;
        e.addr = a;
        push(e, "MEM_RD1");
        e.wrn  = rd;
        e.vs   = 4'b1000;
        e.wr   = 1'b1;
        push(e, "MEM_RD2");
    endtask

    task automatic x_getbd(input logic [2:0] rd);
        ev_t e;
        e     = '0;
        e.rdn = rd;
        e.lb  = 1'b1;
        push(e, "GET_BD");
    endtask

    task automatic x_passb();
        ev_t e;
        e    = '0;
        e.as = 1'b1;
        e.lc = 1'b1;
        push(e, "PASS_B");
    endtask

    task automatic x_wr(input logic [8:0] a);
        ev_t e;
        e      = '0;
        e.cmd  = 2'b10;
        e.addr = a;
        push(e, "MEM_WR");
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            mem[i] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && halted === 1'b1) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 64'({exp_q.size() == 0, halted}), 64'd3);
        exp_q.delete();
    endtask

    initial begin
        int n;
        int n1;
        int p0;
        reset_n      = 1'b0;
        flags        = 3'b000;
        datapath_out = 16'h0014;
        clear_mem();

        fork
            forever begin
                @(negedge clk);
                if (reset_n && (mem_cmd != 2'b00 || write ||
                                loada || loadb || loadc)) begin
                    mon_g = '{cmd: mem_cmd, addr: mem_addr, rdn: readnum,
                              wrn: writenum, wr: write, vs: vsel,
                              la: loada, lb: loadb, lc: loadc, ls: loads,
                              as: asel, bs: bsel, sh: shift, alu: ALUop,
                              imm: sximm8};
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 64'(mon_g), 64'd0);
                    end else begin
                        mon_x = exp_q.pop_front();
                        popped++;
                        if (mon_x.e.vs != 4'b0100) mon_g.imm = mon_x.e.imm;
                        chk(mon_x.tag, 64'(mon_g), 64'(mon_x.e));
                    end
                end
            end
        join_none

        #1;
        chk("reset_ctl", ctl(), 64'd0);
        chk("reset_imm", 64'({sximm5, sximm8}), 64'd0);

        // ADD interrupted by reset while in GET_B
        mem[0] = 16'hA148;
        mem[1] = 16'hE000;
        x_fetch(9'd0);
        x_geta(3'd1);
        x_getb(3'd0, 2'b01);
        release_reset();
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_drain", 64'(exp_q.size()), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_ctl", ctl(), 64'd0);
        chk("mid_reset_imm", 64'({sximm5, sximm8}), 64'd0);

        x_fetch(9'd0);
        x_geta(3'd1);
        x_getb(3'd0, 2'b01);
        x_alu(2'b01, 2'b00, 1'b0, 1'b0);
        x_wc(3'd2);
        x_fetch(9'd1);
        release_reset();
        @(negedge clk);
        #1;
        chk("reset_cycle_cmd", 64'(mem_cmd), 64'd0);
        wait_halt(60, "add_run");

        // MOV, ADD, LDR, STR, then BEQ taken and not taken at address 5
        do_reset();
        clear_mem();
        mem[0] = 16'hD0FD;
        mem[1] = 16'hA148;
        mem[2] = 16'h6162;
        mem[3] = 16'h8162;
        mem[4] = 16'hD105;
        mem[5] = 16'h21FE;
        mem[6] = 16'hE000;
        flags  = 3'b001;
        x_fetch(9'd0);
        x_wimm(3'd0, 16'hFFFD);
        x_fetch(9'd1);
        x_geta(3'd1);
        x_getb(3'd0, 2'b01);
        x_alu(2'b01, 2'b00, 1'b0, 1'b0);
        x_wc(3'd2);
        x_fetch(9'd2);
        x_geta(3'd1);
        x_addr();
        x_rd(9'h014, 3'd3);
        x_fetch(9'd3);
        x_geta(3'd1);
        x_addr();
        x_getbd(3'd3);
        x_passb();
        x_wr(9'h014);
        x_fetch(9'd4);
        x_wimm(3'd1, 16'h0005);
        x_fetch(9'd5);
        n1 = exp_q.size();
        x_fetch(9'd4);
        x_wimm(3'd1, 16'h0005);
        x_fetch(9'd5);
        x_fetch(9'd6);
        p0 = popped;
        release_reset();
        n = 0;
        while (popped < p0 + n1 + 1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("beq_loop_back", 64'(popped >= p0 + n1 + 1), 64'd1);
        flags = 3'b000;
        wait_halt(100, "prog_run");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("halt_hold", 64'({halted, mem_cmd, pc}), 64'({1'b1, 2'b00, 9'd7}));
        end
        reset_n = 1'b0;
        #1;
        chk("halt_cleared", 64'({halted, pc}), 64'd0);

        // BEQ -2 at address 0 wraps to 511
        do_reset();
        clear_mem();
        mem[0]   = 16'h21FE;
        mem[511] = 16'hE000;
        flags    = 3'b001;
        x_fetch(9'd0);
        x_fetch(9'd511);
        release_reset();
        wait_halt(40, "wrap_run");
        chk("wrap_pc", 64'(pc), 64'd0);

        // BNE not taken, BLE taken, CMP, MOV reg, undefined opcode
        do_reset();
        clear_mem();
        mem[0] = 16'h2201;
        mem[1] = 16'h2401;
        mem[2] = 16'hD0FD;
        mem[3] = 16'hA902;
        mem[4] = 16'hC0B3;
        mem[5] = 16'h0000;
        flags  = 3'b001;
        x_fetch(9'd0);
        x_fetch(9'd1);
        x_fetch(9'd3);
        x_geta(3'd1);
        x_getb(3'd2, 2'b00);
        x_alu(2'b00, 2'b01, 1'b1, 1'b0);
        x_fetch(9'd4);
        x_getb(3'd3, 2'b10);
        x_alu(2'b10, 2'b00, 1'b0, 1'b1);
        x_wc(3'd5);
        x_fetch(9'd5);
        release_reset();
        wait_halt(80, "cond_run");
        chk("undef_pc", 64'(pc), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
# cpu_control

Instruction fetch, decode and sequencing unit for the Simple RISC Machine. It fetches 16-bit instructions from memory, holds them in an instruction register, and decodes them. A Moore state machine drives every control input of the register-file/ALU datapath directly downstream (register selects, write-back mux, operand loads, ALU op, immediates, PC). It also owns the program counter, the data-address register and the memory command/address bus.

## Interface
Parameters: none. Fixed widths: 16-bit instruction/data, 9-bit address.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- read_data  in  16  memory read data; valid the cycle after READ is presented
- datapath_out  in  16  datapath C register; source for data-address register
- flags  in  3  datapath status: [0]=Z, [1]=N, [2]=V
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
- mem_addr  out  9  memory address
- pc  out  9  program counter, to datapath write-back mux
- readnum, writenum  out  3 each  register-file selects
- write  out  1  register-file write enable
- vsel  out  4  one-hot write-back select: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata
- loada, loadb, loadc, loads  out  1 each  datapath register loads
- asel, bsel  out  1 each  A-operand zero select, B-operand sximm5 select
- shift, ALUop  out  2 each
- sximm5, sximm8  out  16 each  sign-extended IR[4:0], IR[7:0]
- halted  out  1  high in HALT state

## Operation
- Fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], Rm IR[2:0], cond IR[10:8].
- Outputs are functions of state and IR only. All unlisted controls are 0 in every state. mem_cmd is NONE unless stated.
- RESET → IF1: pc←0.
- IF1: mem_addr=pc, READ → IF2.
- IF2: mem_addr=pc, READ; IR←read_data → UPDATE_PC.
- UPDATE_PC: pc←pc+1 mod 512 → DECODE.
- DECODE dispatches on opcode/op:
  - MOV imm (110/10): WRITE_IMM (writenum=Rn, vsel=0100, write) → IF1.
  - MOV reg (110/00): GET_B → ALU → WRITE_C.
  - ALU ops (101/op): GET_A → GET_B → ALU. CMP (op=01) → IF1; all others → WRITE_C.
  - LDR (011/00): GET_A → ADDR → LOAD_ADDR → MEM_RD1 (mem_addr=addr_reg, READ) → MEM_RD2 (READ, writenum=Rd, vsel=1000, write) → IF1.
  - STR (100/00): GET_A → ADDR → LOAD_ADDR → GET_BD (readnum=Rd, loadb) → PASS_B (asel, ALUop=00, loadc, shift=00) → MEM_WR (mem_addr=addr_reg, WRITE) → IF1.
  - B (001/00): BRANCH; if taken, pc←pc+sximm8[8:0] mod 512 → IF1. Conditions: cond 000 always, 001 Z, 010 !Z, 011 N≠V, 100 Z|(N≠V); 101–111 never taken.
  - HALT (111) and any undefined encoding: HALT (halted=1), absorbing until reset.
- Execute-state controls:
  - GET_A: readnum=Rn, loada.
  - GET_B: readnum=Rm, loadb, shift=IR[4:3].
  - ALU: shift=IR[4:3], loadc. MOV reg: asel=1, ALUop=00. ALU ops: ALUop=op; loads=1 only for CMP.
  - WRITE_C: writenum=Rd, vsel=0001, write.
  - ADDR: bsel, ALUop=00, loadc.
  - LOAD_ADDR: addr_reg←datapath_out[8:0].

## Timing
- Reset clears asynchronously, mid-instruction included: state=RESET, pc=0, IR=0, addr_reg=0, mem_cmd=NONE, all controls 0, halted=0. The first IF1 follows one cycle after reset_n rises.
- Cycles per instruction, IF1 to the next IF1: MOV imm 5, B 5, MOV reg 7, CMP 7, ADD/AND/MVN 8, LDR 9, STR 10.
- Branch offset is relative to pc+1, the instruction after the branch.
- The flags sampled in BRANCH are those latched by the most recent CMP.

## Structure
- Shared package cpu_pkg holds the opcode/op constants, state encoding, mem_cmd codes and vsel one-hot codes.
- One combinational sub-module, instr_dec: IR → field selects, sximm5/sximm8, shift.
- cpu_control contains the FSM, IR, pc and addr_reg.

## Test plan
- Reset mid-instruction: drop reset_n during GET_B of an ADD → outputs zero immediately. After release: one RESET cycle, then IF1 with mem_addr=0, mem_cmd=01.
- MOV R0,#-3 (0xD0FD) at address 0 → cycle 5: writenum=0, vsel=0100, write=1, sximm8=0xFFFD. Next IF1 has pc=1.
- ADD R2,R1,R0,LSL#1 (0xA148) → three cycles in order: (1) readnum=1, loada; (2) readnum=0, loadb, shift=01; (3) ALUop=00, loadc, loads=0. Then writenum=2, vsel=0001, write.
- BEQ −2 (0x21FE) at address 5: with flags=001 → next fetch at mem_addr=4. With flags=000 → next fetch at 6. Repeat BEQ −2 at address 0 → fetch at 511 (wrap).
- LDR R3,[R1,#2] (0x6162), bench supplies datapath_out=0x0014 → MEM_RD1/MEM_RD2 both show mem_addr=0x014, mem_cmd=01. MEM_RD2 asserts write, writenum=3, vsel=1000. STR R3,[R1,#2] (0x8162) → MEM_WR shows mem_addr=0x014, mem_cmd=10.
- HALT (0xE000) → halted=1; mem_cmd=00 and pc frozen for 20 cycles. Reset pulse clears halted.
